passthru_skid: RTL and testbench

PASSTHRU_SKID -- requirements
Module: passthru_skid

---
 rtl/passthru_skid.sv | 110 +++++++++++
 tb/tb_passthru_skid.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/passthru_skid.sv
// Two-entry in-order skid buffer; I_ready and O_valid come straight from flops, optional trace via PASSTHRU_SKID_TRACE_EN.
// Latency: a word pushed into an empty (or draining single-entry) buffer is on O_data one cycle later.
// Backpressure: I_ready drops only once both entries are full, so it never depends combinationally on O_ready.
module passthru_skid #(
    parameter int WIDTH = 8,
    parameter int ID    = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I_data,
    input  logic             I_valid,
    output logic             I_ready,
    output logic [WIDTH-1:0] O_data,
    output logic             O_valid,
    input  logic             O_ready,
    output logic [15:0]      xfer_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [WIDTH-1:0] head_d;
    logic             head_load;
    logic             tail_load;
    logic             push;
    logic             pop;

    assign push   = I_valid && I_ready;
    assign pop    = O_valid && O_ready;
    assign O_data = head_q;

    always_comb begin
        state_d   = state_q;
        head_d    = I_data;
        head_load = 1'b0;
        tail_load = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d   = ONE;
                    head_load = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_load = 1'b1;
                end else if (push) begin
                    state_d   = TWO;
                    tail_load = 1'b1;
                end else if (pop) begin
                    state_d   = EMPTY;
                end
            end
            TWO: begin
                // I_ready is low here, so the only movement is tail advancing to head
                if (pop) begin
                    state_d   = ONE;
                    head_d    = tail_q;
                    head_load = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= EMPTY;
            I_ready    <= 1'b1;
            O_valid    <= 1'b0;
            xfer_count <= 16'd0;
        end else begin
            state_q <= state_d;
            I_ready <= (state_d != TWO);
            O_valid <= (state_d != EMPTY);
            if (pop) begin
                xfer_count <= xfer_count + 16'd1;
            end
        end
    end

    // Entry storage carries no reset; validity is tracked by state_q alone
    always_ff @(posedge CLK) begin
        if (head_load) begin
            head_q <= head_d;
        end
        if (tail_load) begin
            tail_q <= I_data;
        end
    end

`ifdef PASSTHRU_SKID_TRACE_EN
    always @(posedge CLK) begin
        if (!RESET && pop) begin
            $display("Id = %0d xfer %h", ID, O_data);
        end
    end
`else
    logic [31:0] unused_id;
    assign unused_id = ID;
`endif

endmodule

// File: tb/tb_passthru_skid.sv
// Randomised and directed bench for passthru_skid against a queue-based reference model.
module tb_passthru_skid;

    localparam int WIDTH = 16;

    logic             CLK;
    logic             RESET;
    logic [WIDTH-1:0] I_data;
    logic             I_valid;
    logic             I_ready;
    logic [WIDTH-1:0] O_data;
    logic             O_valid;
    logic             O_ready;
    logic [15:0]      xfer_count;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    logic [WIDTH-1:0] mq[$];
    logic [15:0]      m_cnt = 16'd0;

    passthru_skid #(.WIDTH(WIDTH), .ID(1)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .I_data     (I_data),
        .I_valid    (I_valid),
        .I_ready    (I_ready),
        .O_data     (O_data),
        .O_valid    (O_valid),
        .O_ready    (O_ready),
        .xfer_count (xfer_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference: a FIFO of at most two words; push when not full, pop when non-empty and O_ready.
    always @(posedge CLK) begin
        bit do_pop;
        bit do_push;
        if (RESET) begin
            mq.delete();
            m_cnt = 16'd0;
        end else begin
            do_pop  = (mq.size() > 0) && (O_ready === 1'b1);
            do_push = (I_valid === 1'b1) && (mq.size() < 2);
            if (do_pop) begin
                void'(mq.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (do_push) mq.push_back(I_data);
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_i_ready", {31'd0, I_ready}, {31'd0, mq.size() < 2});
            check("model_o_valid", {31'd0, O_valid}, {31'd0, mq.size() > 0});
            check("model_xfer_count", {16'd0, xfer_count}, {16'd0, m_cnt});
            if (mq.size() > 0) check("model_o_data", {16'd0, O_data}, {16'd0, mq[0]});
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int next_in;
        int next_out;
        int cycles;
        int pops;
        bit acc;
        bit popped;

        RESET   = 1'b1;
        I_valid = 1'b0;
        I_data  = '0;
        O_ready = 1'b0;
        step();
        chk_en = 1;
        step();
        check("reset_o_valid", {31'd0, O_valid}, 32'd0);
        check("reset_i_ready", {31'd0, I_ready}, 32'd1);
        check("reset_xfer_count", {16'd0, xfer_count}, 32'd0);
        RESET = 1'b0;

        // Single word from empty, downstream ready
        I_valid = 1'b1; I_data = 16'h0011; O_ready = 1'b1;
        step();
        I_valid = 1'b0;
        check("first_o_valid", {31'd0, O_valid}, 32'd1);
        check("first_o_data", {16'd0, O_data}, 32'h11);
        check("first_cnt_before_pop", {16'd0, xfer_count}, 32'd0);
        step();
        check("first_cnt_after_pop", {16'd0, xfer_count}, 32'd1);
        check("first_drained", {31'd0, O_valid}, 32'd0);

        RESET = 1'b1; step(); RESET = 1'b0;

        // Fill while stalled, then drain with a third word waiting
        O_ready = 1'b0;
        I_valid = 1'b1; I_data = 16'h00A1; step();
        I_data = 16'h00A2; step();
        check("full_i_ready", {31'd0, I_ready}, 32'd0);
        check("full_head", {16'd0, O_data}, 32'hA1);
        I_data = 16'h00A3; step(); step();
        check("stall_head_stable", {16'd0, O_data}, 32'hA1);
        check("stall_i_ready", {31'd0, I_ready}, 32'd0);
        O_ready = 1'b1;
        step();
        check("drain_1", {16'd0, O_data}, 32'hA2);
        check("drain_1_ready", {31'd0, I_ready}, 32'd1);
        step();
        I_valid = 1'b0;
        check("drain_2", {16'd0, O_data}, 32'hA3);
        step();
        check("drain_3_empty", {31'd0, O_valid}, 32'd0);
        check("drain_cnt", {16'd0, xfer_count}, 32'd3);

        // Reset held two cycles while full, with push/pop requested
        O_ready = 1'b0;
        I_valid = 1'b1; I_data = 16'h0B01; step();
        I_data = 16'h0B02; step();
        check("pre_reset_full", {31'd0, I_ready}, 32'd0);
        RESET = 1'b1; O_ready = 1'b1; step(); step();
        RESET = 1'b0; I_valid = 1'b0;
        check("midrst_o_valid", {31'd0, O_valid}, 32'd0);
        check("midrst_i_ready", {31'd0, I_ready}, 32'd1);
        check("midrst_cnt", {16'd0, xfer_count}, 32'd0);
        I_valid = 1'b1; I_data = 16'h0055; step();
        I_valid = 1'b0;
        check("post_rst_push", {16'd0, O_data}, 32'h55);
        step();

        // Random valid/ready, words 0..999
        RESET = 1'b1; step(); RESET = 1'b0;
        next_in = 0; next_out = 0; cycles = 0;
        while (next_out < 1000 && cycles < 20000) begin
            I_valid = (next_in < 1000) && ($urandom_range(0, 3) != 0);
            I_data  = next_in[WIDTH-1:0];
            O_ready = ($urandom_range(0, 3) != 0);
            acc    = I_valid && I_ready;
            popped = O_valid && O_ready;
            if (popped) begin
                check("rand_order", {16'd0, O_data}, next_out);
                next_out++;
            end
            step();
            if (acc) next_in++;
            cycles++;
        end
        I_valid = 1'b0;
        check("rand_all_out", next_out, 32'd1000);
        check("rand_cnt", {16'd0, xfer_count}, 32'd1000);

        // Sustained streaming up to the counter wrap
        RESET = 1'b1; step(); RESET = 1'b0;
        I_valid = 1'b1; O_ready = 1'b1;
        pops = 0; cycles = 0;
        while (pops < 65535 && cycles < 70000) begin
            I_data = cycles[WIDTH-1:0];
            if (O_valid && O_ready) pops++;
            step();
            cycles++;
        end
        I_valid = 1'b0;
        check("stream_cycles", cycles, 32'd65536);
        check("cnt_max", {16'd0, xfer_count}, 32'd65535);
        step();
        check("cnt_wrap", {16'd0, xfer_count}, 32'd0);
        step();

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
